// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: grant FSM states and grant owners.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Saturating busy-cycle counter; expired flags the last cycle the arbiter may
// wait for the memory before abandoning the access.
module arb_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: clear wins, otherwise count up until saturated
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (enable && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory between the fetch (I)
// and memory-stage (D) ports, with done pulses, global stall and sticky timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              stall,
  output logic              err
);

  state_e            state_q, state_d;
  gnt_e              last_q, last_d;
  logic              m_en_q, m_en_d;
  logic              m_wr_q, m_wr_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic              err_q, err_d;
  logic              tmr_clr_s;
  logic              tmr_exp_s;
  logic              busy_s;

  assign busy_s = (state_q == BUSY_I) || (state_q == BUSY_D);

  arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clr_s),
    .enable  (busy_s),
    .expired (tmr_exp_s)
  );

  // grant decision, completion handling and next values of every register
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    m_en_d    = m_en_q;
    m_wr_d    = m_wr_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    err_d     = err_q;
    tmr_clr_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req && (!d_req || (last_q == GNT_D))) begin
          state_d   = BUSY_I;
          last_d    = GNT_I;
          m_en_d    = 1'b1;
          m_wr_d    = 1'b0;
          m_addr_d  = i_addr;
          m_wdata_d = {DATA_W{1'b0}};
          tmr_clr_s = 1'b1;
        end else if (d_req) begin
          state_d   = BUSY_D;
          last_d    = GNT_D;
          m_en_d    = 1'b1;
          m_wr_d    = d_wr;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          tmr_clr_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_I: begin
        if (m_ready || tmr_exp_s) begin
          // m_ready takes priority over a coincident timeout
          i_rdata_d = m_ready ? m_rdata : {DATA_W{1'b0}};
          err_d     = err_q | ~m_ready;
          m_en_d    = 1'b0;
          i_done_d  = 1'b1;
          state_d   = DONE;
        end else begin
          state_d = BUSY_I;
        end
      end
      BUSY_D: begin
        if (m_ready || tmr_exp_s) begin
          d_rdata_d = (m_ready && !m_wr_q) ? m_rdata : {DATA_W{1'b0}};
          err_d     = err_q | ~m_ready;
          m_en_d    = 1'b0;
          m_wr_d    = 1'b0;
          d_done_d  = 1'b1;
          state_d   = DONE;
        end else begin
          state_d = BUSY_D;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_q    <= GNT_D;
      m_en_q    <= 1'b0;
      m_wr_q    <= 1'b0;
      m_addr_q  <= {ADDR_W{1'b0}};
      m_wdata_q <= {DATA_W{1'b0}};
      i_rdata_q <= {DATA_W{1'b0}};
      d_rdata_q <= {DATA_W{1'b0}};
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      m_en_q    <= m_en_d;
      m_wr_q    <= m_wr_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      err_q     <= err_d;
    end
  end

  assign i_done  = i_done_q;
  assign d_done  = d_done_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign m_en    = m_en_q;
  assign m_wr    = m_wr_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign err     = err_q;
  // held low while in reset so every output reads 0 during reset
  assign stall   = rst & (i_req | d_req) & ~(i_done_q | d_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single-port accesses plus
// hand-written reset, contention and reset-mid-access sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = 16'h0000;
  logic        i_done;
  logic [15:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_wr = 1'b0;
  logic [15:0] d_addr = 16'h0000;
  logic [15:0] d_wdata = 16'h0000;
  logic        d_done;
  logic [15:0] d_rdata;
  logic        m_en;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata = 16'h0000;
  logic        m_ready = 1'b0;
  logic        stall;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        port_d;
    logic        wr;
    logic        drop;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mem;
    int          lat;
    int          exp_edge;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [9];

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .m_en(m_en), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one access from an idle arbiter; lat = BUSY cycle carrying m_ready, 0 = never
  task automatic run_vec(input vec_t v);
    logic seen;
    seen = 1'b0;
    if (v.port_d) begin
      d_req = 1'b1; d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    m_rdata = v.mem;
    m_ready = 1'b0;
    for (int e = 1; e <= 40 && !seen; e++) begin
      step();
      if (i_done || d_done) begin
        seen = 1'b1;
        check("done_edge", e, v.exp_edge);
        check("done_port", {31'd0, d_done}, {31'd0, v.port_d});
        check("done_excl", {31'd0, i_done & d_done}, 32'd0);
        check("rdata", v.port_d ? d_rdata : i_rdata, {16'd0, v.exp_rdata});
        check("err", {31'd0, err}, {31'd0, v.exp_err});
        check("stall_done", {31'd0, stall}, 32'd0);
        check("m_en_done", {31'd0, m_en}, 32'd0);
      end else begin
        check("m_en_busy", {31'd0, m_en}, 32'd1);
        check("m_addr_busy", m_addr, {16'd0, v.addr});
        check("m_wr_busy", {31'd0, m_wr}, {31'd0, v.port_d & v.wr});
        if (v.port_d && v.wr) check("m_wdata_busy", m_wdata, {16'd0, v.wdata});
        check("stall_busy", {31'd0, stall}, {31'd0, !(v.drop && e > 1)});
      end
      if (e == 1 && v.drop) begin
        i_req = 1'b0; d_req = 1'b0;
      end
      if (e == 2) begin
        i_addr = ~v.addr; d_addr = ~v.addr; d_wdata = ~v.wdata;
      end
      m_ready = (v.lat != 0) && (e == v.lat) && !seen;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; m_ready = 1'b0;
    step();
    check("idle_no_done", {31'd0, i_done | d_done}, 32'd0);
    check("idle_m_en", {31'd0, m_en}, 32'd0);
  endtask

  initial begin
    logic seen;
    vec_t fin;
    //        port wr drop addr      wdata     mem       lat edge rdata     err
    vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'hA5A5, 1, 2, 16'hA5A5, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 3, 4, 16'hBEEF, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'h1234, 16'hFFFF, 2, 3, 16'h0000, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h7E7E, 5, 6, 16'h7E7E, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 16'h0022, 16'h0000, 16'h00FF, 2, 3, 16'h00FF, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 16'h0300, 16'h0000, 16'hC3C3, 15, 16, 16'hC3C3, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 16'h0200, 16'h0000, 16'hDEAD, 0, 16, 16'h0000, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 16'h0500, 16'h0000, 16'h1357, 1, 2, 16'h1357, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 16'h0600, 16'h0000, 16'h2468, 0, 16, 16'h0000, 1'b1};

    // reset held with both requests asserted
    i_req = 1'b1; d_req = 1'b1; i_addr = 16'h0AAA; d_addr = 16'h0DDD;
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst_m_en", {31'd0, m_en}, 32'd0);
      check("rst_done", {30'd0, i_done, d_done}, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_rdata", {i_rdata, d_rdata}, 32'd0);
      check("rst_m_addr", m_addr, 32'd0);
    end
    rst = 1'b1;
    step();
    check("first_grant_m_en", {31'd0, m_en}, 32'd1);
    check("first_grant_is_i", m_addr, 32'h0AAA);

    // contention: both held, grants must alternate I, D, I, D
    m_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      m_rdata = 16'h1000 + 16'(g);
      seen = 1'b0;
      for (int c = 0; c < 6 && !seen; c++) begin
        step();
        check("cont_excl", {31'd0, i_done & d_done}, 32'd0);
        if (i_done || d_done) begin
          seen = 1'b1;
          check("cont_port", {31'd0, d_done}, g % 2);
          check("cont_addr", m_addr, (g % 2 == 1) ? 32'h0DDD : 32'h0AAA);
          check("cont_rdata", (g % 2 == 1) ? d_rdata : i_rdata, 32'h1000 + g);
        end
      end
      if (!seen) check("cont_timeout", 32'd0, 32'd1);
    end
    i_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
    step();
    check("cont_end_m_en", {31'd0, m_en}, 32'd0);

    for (int k = 0; k < 9; k++) run_vec(vecs[k]);

    // reset during BUSY_I with m_ready present, then stray m_ready while idle
    i_req = 1'b1; i_addr = 16'h0700;
    step();
    check("pre_rst_m_en", {31'd0, m_en}, 32'd1);
    check("pre_rst_err", {31'd0, err}, 32'd1);
    rst = 1'b0; m_ready = 1'b1; m_rdata = 16'hFFFF;
    step();
    check("midrst_m_en", {31'd0, m_en}, 32'd0);
    check("midrst_done", {30'd0, i_done, d_done}, 32'd0);
    check("midrst_err", {31'd0, err}, 32'd0);
    rst = 1'b1; i_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("stray_m_en", {31'd0, m_en}, 32'd0);
      check("stray_done", {30'd0, i_done, d_done}, 32'd0);
      check("stray_rdata", {16'd0, i_rdata}, 32'd0);
    end
    m_ready = 1'b0;
    fin = '{1'b0, 1'b0, 1'b0, 16'h0800, 16'h0000, 16'h4242, 2, 3, 16'h4242, 1'b0};
    run_vec(fin);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
